// File: rtl/sa_stream.sv
// rtl/sa_stream.sv - weight-stationary systolic array with streaming ifmap vectors
// Weights load row by row, ifmap vectors stream through a skewed PE grid, outputs are deskewed per vector.
module sa_stream #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 32,
  parameter int SIGNED     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             w_valid_i,
  output logic                             w_ready_o,
  input  logic [DATA_WIDTH*COLS-1:0]       w_data_i,
  input  logic                             x_valid_i,
  output logic                             x_ready_o,
  input  logic [DATA_WIDTH*ROWS-1:0]       x_data_i,
  input  logic                             x_last_i,
  output logic                             y_valid_o,
  output logic [PSUM_WIDTH*COLS-1:0]       y_data_o,
  output logic                             y_last_o,
  output logic                             busy_o
);

  localparam int LAT = ROWS + COLS;
  localparam int CW  = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [CW-1:0]   wrow;
  logic            rdy_en;
  logic            w_fire, x_fire;

  logic [DATA_WIDTH-1:0] w_q  [ROWS][COLS];
  logic [DATA_WIDTH-1:0] sk   [ROWS][ROWS];
  logic [DATA_WIDTH-1:0] x_q  [ROWS][COLS];
  logic [DATA_WIDTH-1:0] pe_x [ROWS][COLS];
  logic [PSUM_WIDTH-1:0] ps_q [ROWS][COLS];
  logic [PSUM_WIDTH-1:0] pe_p [ROWS][COLS];
  logic [PSUM_WIDTH-1:0] ds   [COLS][COLS];
  logic [PSUM_WIDTH*COLS-1:0] y_next;
  logic [LAT-1:0]        vp, lp;

  // Operands are widened before the multiply so the product wraps at PSUM_WIDTH.
  function automatic logic [PSUM_WIDTH-1:0] mul_ext(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic [PSUM_WIDTH-1:0] ae, be;
    if (SIGNED != 0) begin
      ae = PSUM_WIDTH'($signed(a));
      be = PSUM_WIDTH'($signed(b));
    end else begin
      ae = PSUM_WIDTH'(a);
      be = PSUM_WIDTH'(b);
    end
    return ae * be;
  endfunction

  assign w_ready_o = rdy_en && (state == IDLE || state == LOAD);
  assign x_ready_o = (state == COMPUTE);
  assign busy_o    = (state != IDLE);
  assign w_fire    = w_valid_i && w_ready_o;
  assign x_fire    = x_valid_i && x_ready_o;
  assign wrow      = (state == LOAD) ? cnt : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rdy_en <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (w_fire) begin
        cnt_n   = (ROWS == 1) ? '0 : CW'(1);
        state_n = (ROWS == 1) ? COMPUTE : LOAD;
      end
      LOAD: if (w_fire) begin
        if (cnt == CW'(ROWS - 1)) begin
          state_n = COMPUTE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      COMPUTE: if (x_fire && x_last_i) begin
        state_n = DRAIN;
        cnt_n   = '0;
      end
      DRAIN: if (cnt == CW'(LAT - 1)) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          w_q[r][c] <= '0;
    end else if (w_fire) begin
      for (int r = 0; r < ROWS; r++)
        if (wrow == CW'(r))
          for (int c = 0; c < COLS; c++)
            w_q[r][c] <= w_data_i[DATA_WIDTH*c +: DATA_WIDTH];
    end
  end

  // Row r of the ifmap reaches column 0 after r extra cycles; bubbles enter as zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int i = 0; i < ROWS; i++)
          sk[r][i] <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        sk[r][0] <= x_fire ? x_data_i[DATA_WIDTH*r +: DATA_WIDTH] : '0;
        for (int i = 1; i < ROWS; i++)
          sk[r][i] <= sk[r][i-1];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        pe_x[r][c] = (c == 0) ? sk[r][r] : x_q[r][(c == 0) ? 0 : c - 1];
        pe_p[r][c] = (r == 0) ? '0 : ps_q[(r == 0) ? 0 : r - 1][c];
      end
    end
  end

  // Ifmap moves right, partial sums move down; each PE adds its product to the sum from above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          x_q[r][c]  <= '0;
          ps_q[r][c] <= '0;
        end
    end else begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          x_q[r][c]  <= pe_x[r][c];
          ps_q[r][c] <= pe_p[r][c] + mul_ext(pe_x[r][c], w_q[r][c]);
        end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < COLS; c++)
        for (int i = 0; i < COLS; i++)
          ds[c][i] <= '0;
    end else begin
      for (int c = 0; c < COLS; c++) begin
        ds[c][0] <= ps_q[ROWS-1][c];
        for (int i = 1; i < COLS; i++)
          ds[c][i] <= ds[c][i-1];
      end
    end
  end

  // Column c finishes c cycles after column 0, so it is delayed COLS-1-c cycles to line up.
  always_comb begin
    y_next = '0;
    for (int c = 0; c < COLS; c++) begin
      if (c == COLS - 1)
        y_next[PSUM_WIDTH*c +: PSUM_WIDTH] = ps_q[ROWS-1][c];
      else
        y_next[PSUM_WIDTH*c +: PSUM_WIDTH] = ds[c][(c >= COLS - 1) ? 0 : COLS - 2 - c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vp        <= '0;
      lp        <= '0;
      y_valid_o <= 1'b0;
      y_last_o  <= 1'b0;
      y_data_o  <= '0;
    end else begin
      vp        <= {vp[LAT-2:0], x_fire};
      lp        <= {lp[LAT-2:0], x_fire && x_last_i};
      y_valid_o <= vp[LAT-1];
      y_last_o  <= vp[LAT-1] && lp[LAT-1];
      if (vp[LAT-1])
        y_data_o <= y_next;
    end
  end

endmodule
